// File: rtl/mem_readback.sv
// Memory readback streamer: reads a run of words and sends each as a
// 3-byte UART frame {SYNC, addr, data}, mirroring the host write frame.
module mem_readback #(
    parameter int unsigned RD_LAT = 1,
    parameter logic [7:0]  SYNC   = 8'hFF
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD      = 4'd1;
    localparam logic [3:0] S_RD_WAIT = 4'd2;
    localparam logic [3:0] S_TX_SYNC = 4'd3;
    localparam logic [3:0] S_W_SYNC  = 4'd4;
    localparam logic [3:0] S_TX_ADDR = 4'd5;
    localparam logic [3:0] S_W_ADDR  = 4'd6;
    localparam logic [3:0] S_TX_DATA = 4'd7;
    localparam logic [3:0] S_W_DATA  = 4'd8;
    localparam logic [3:0] S_NEXT    = 4'd9;
    localparam logic [3:0] S_FIN     = 4'd10;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    logic [3:0] state;
    logic [7:0] addr;
    logic [7:0] remaining;
    logic [7:0] data_q;
    logic [2:0] lat_cnt;
    logic       guard;

    // done is decoded from FIN so it lands in the cycle right after acceptance
    // for an empty run, and drops together with the async reset.
    assign done = (state == S_FIN);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            data_q    <= '0;
            lat_cnt   <= '0;
            guard     <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            tx_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr      <= (req_addr == 8'hFF) ? 8'hFE : req_addr;
                        remaining <= req_len;
                        busy      <= 1'b1;
                        state     <= (req_len == 8'd0) ? S_FIN : S_RD;
                    end
                end
                S_RD: begin
                    mem_addr  <= addr;
                    mem_rd_en <= 1'b1;
                    lat_cnt   <= '0;
                    state     <= S_RD_WAIT;
                end
                // lat_cnt is 0 in the strobe cycle; data is valid once it reaches LAT
                S_RD_WAIT: begin
                    if (lat_cnt == LAT) begin
                        data_q <= (mem_rdata == SYNC) ? SYNC - 8'd1 : mem_rdata;
                        state  <= S_TX_SYNC;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_TX_SYNC: begin
                    if (!tx_busy) begin
                        tx_data  <= SYNC;
                        tx_start <= 1'b1;
                        guard    <= 1'b1;
                        state    <= S_W_SYNC;
                    end
                end
                S_W_SYNC: begin
                    if (guard)         guard <= 1'b0;
                    else if (!tx_busy) state <= S_TX_ADDR;
                end
                S_TX_ADDR: begin
                    if (!tx_busy) begin
                        tx_data  <= addr;
                        tx_start <= 1'b1;
                        guard    <= 1'b1;
                        state    <= S_W_ADDR;
                    end
                end
                S_W_ADDR: begin
                    if (guard)         guard <= 1'b0;
                    else if (!tx_busy) state <= S_TX_DATA;
                end
                S_TX_DATA: begin
                    if (!tx_busy) begin
                        tx_data  <= data_q;
                        tx_start <= 1'b1;
                        guard    <= 1'b1;
                        state    <= S_W_DATA;
                    end
                end
                S_W_DATA: begin
                    if (guard)         guard <= 1'b0;
                    else if (!tx_busy) state <= S_NEXT;
                end
                S_NEXT: begin
                    remaining <= remaining - 8'd1;
                    addr      <= (addr == 8'hFE) ? 8'h00 : addr + 8'd1;
                    state     <= (remaining == 8'd1) ? S_FIN : S_RD;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: random memory, UART TX busy model, and a frame-level
// reference built from the readback rules; two instances cover RD_LAT 1 and 3.
module tb_mem_readback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req, sel, hold;
    logic [7:0] req_addr, req_len;

    logic [7:0] mem_addr0, mem_addr1, tx_data0, tx_data1;
    logic       mem_rd_en0, mem_rd_en1, tx_start0, tx_start1;
    logic       busy0, busy1, done0, done1;
    logic       req0, req1, tx_busy0, tx_busy1;

    logic [7:0] mem_addr, tx_data, mem_rdata;
    logic       mem_rd_en, tx_start, busy, done, tx_busy;

    assign req0      = req & ~sel;
    assign req1      = req & sel;
    assign tx_busy0  = sel ? 1'b0 : tx_busy;
    assign tx_busy1  = sel ? tx_busy : 1'b0;
    assign mem_addr  = sel ? mem_addr1  : mem_addr0;
    assign mem_rd_en = sel ? mem_rd_en1 : mem_rd_en0;
    assign tx_data   = sel ? tx_data1   : tx_data0;
    assign tx_start  = sel ? tx_start1  : tx_start0;
    assign busy      = sel ? busy1      : busy0;
    assign done      = sel ? done1      : done0;

    mem_readback #(.RD_LAT(1), .SYNC(8'hFF)) u_dut0 (
        .clk_in(clk), .reset(reset), .req(req0), .req_addr(req_addr), .req_len(req_len),
        .mem_addr(mem_addr0), .mem_rd_en(mem_rd_en0), .mem_rdata(mem_rdata),
        .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0),
        .busy(busy0), .done(done0)
    );

    mem_readback #(.RD_LAT(3), .SYNC(8'hFF)) u_dut1 (
        .clk_in(clk), .reset(reset), .req(req1), .req_addr(req_addr), .req_len(req_len),
        .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata),
        .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(tx_busy1),
        .busy(busy1), .done(done1)
    );

    // Memory: read data appears exactly lat cycles after the strobe, garbage otherwise.
    logic [7:0] mem [256];
    logic [7:0] pipe [4];
    always @(posedge clk) begin
        pipe[0] <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[sel ? 2 : 0];

    // UART TX: busy for busy_len cycles starting the cycle after tx_start.
    int         busy_cnt = 0;
    int         busy_len = 10;
    int         rd_n = 0;
    int         done_n = 0;
    logic [7:0] got [$];
    always @(posedge clk) begin
        if (tx_start) begin
            got.push_back(tx_data);
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (mem_rd_en) rd_n <= rd_n + 1;
        if (done) done_n <= done_n + 1;
    end
    assign tx_busy = hold | (busy_cnt != 0);

    int         vectors = 0;
    int         errors = 0;
    logic [7:0] exp [$];
    int         base_g, base_rd, base_d;
    bit         stab_on = 0;

    function automatic logic [7:0] clamp(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFE : v;
    endfunction

    function automatic void build_exp(input logic [7:0] start, input int len);
        logic [7:0] a;
        exp.delete();
        a = (start == 8'hFF) ? 8'hFE : start;
        for (int i = 0; i < len; i++) begin
            exp.push_back(8'hFF);
            exp.push_back(a);
            exp.push_back(clamp(mem[a]));
            a = (a == 8'hFE) ? 8'h00 : a + 8'd1;
        end
    endfunction

    task automatic tick();
        int n;
        @(negedge clk);
        vectors++;
        if (mem_rd_en === 1'b1 && tx_start === 1'b1) begin
            errors++;
            $display("FAIL excl: mem_rd_en=%b tx_start=%b both high", mem_rd_en, tx_start);
        end
        n = got.size() - base_g;
        if (stab_on && busy_cnt != 0 && n > 0 && n <= exp.size()) begin
            vectors++;
            if (tx_data !== exp[n-1]) begin
                errors++;
                $display("FAIL tx_hold: tx_data=%h expected %h", tx_data, exp[n-1]);
            end
        end
    endtask

    task automatic snap();
        base_g  = got.size();
        base_rd = rd_n;
        base_d  = done_n;
    endtask

    task automatic start_req(input logic [7:0] a, input logic [7:0] len);
        @(negedge clk);
        req = 1'b1; req_addr = a; req_len = len;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        tick();
        tick();
    endtask

    task automatic check_run(input string name, input int len);
        int n;
        n = got.size() - base_g;
        vectors++;
        if (n !== exp.size()) begin
            errors++;
            $display("FAIL %s_nbytes: got %0d expected %0d", name, n, exp.size());
        end else begin
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (got[base_g+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h expected %h", name, i, got[base_g+i], exp[i]);
                end
            end
        end
        vectors++;
        if (rd_n - base_rd !== len) begin
            errors++;
            $display("FAIL %s_reads: got %0d expected %0d", name, rd_n - base_rd, len);
        end
        vectors++;
        if (done_n - base_d !== 1) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses expected 1", name, done_n - base_d);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 0", name, busy);
        end
    endtask

    task automatic run(input string name, input logic [7:0] a, input int len);
        snap();
        build_exp(a, len);
        stab_on = 1;
        start_req(a, 8'(len));
        wait_done(name, len * 3 * (busy_len + 6) + 100);
        stab_on = 0;
        check_run(name, len);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; req_addr = '0; req_len = '0; sel = 1'b0; hold = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({mem_addr, mem_rd_en, tx_data, tx_start, busy, done} !== 20'd0) begin
            errors++;
            $display("FAIL reset: outputs=%h expected 0", {mem_addr, mem_rd_en, tx_data, tx_start, busy, done});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        busy_len = 10;
        mem[8'h10] = 8'h42;
        run("single", 8'h10, 1);
    endtask

    task automatic test_burst();
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;
        run("burst", 8'h20, 3);
    endtask

    task automatic test_clamp_wrap();
        mem[8'h05] = 8'hFF;
        run("clamp", 8'h05, 1);
        mem[8'hFE] = 8'h00;
        run("wrap", 8'hFE, 2);
        run("addr255", 8'hFF, 2);
    endtask

    task automatic test_zero_len();
        snap();
        @(negedge clk);
        req = 1'b1; req_addr = 8'h33; req_len = 8'd0;
        @(negedge clk);
        req = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_accept: done=%b busy=%b expected 1 1", done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (3) tick();
        vectors++;
        if (got.size() - base_g !== 0 || rd_n - base_rd !== 0 || done_n - base_d !== 1) begin
            errors++;
            $display("FAIL zero_counts: tx=%0d rd=%0d done=%0d expected 0 0 1",
                     got.size() - base_g, rd_n - base_rd, done_n - base_d);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            busy_len = $urandom_range(1, 15);
            run("random", 8'($urandom), $urandom_range(1, 6));
        end
    endtask

    task automatic test_back_to_back();
        busy_len = 1;
        run("b2b_a", 8'($urandom), 4);
        run("b2b_b", 8'($urandom), 3);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        busy_len = 10;
        snap();
        build_exp(8'h40, 3);
        start_req(8'h40, 8'd3);
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (tx_start === 1'b1 && got.size() - base_g == 1) hit = 1;
        end
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_timeout: addr byte start not seen");
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({tx_start, busy, done, mem_rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: tx_start,busy,done,rd_en=%b expected 0000", {tx_start, busy, done, mem_rd_en});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run("post_reset", 8'h50, 2);
    endtask

    task automatic test_lat3();
        sel = 1'b1;
        busy_len = 8;
        hold = 1'b1;
        snap();
        build_exp(8'h70, 2);
        start_req(8'h70, 8'd2);
        repeat (50) tick();
        vectors++;
        if (got.size() - base_g !== 0 || rd_n - base_rd !== 1) begin
            errors++;
            $display("FAIL lat3_hold: tx=%0d rd=%0d expected 0 1", got.size() - base_g, rd_n - base_rd);
        end
        hold = 1'b0;
        stab_on = 1;
        wait_done("lat3", 300);
        stab_on = 0;
        check_run("lat3", 2);
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        base_g = 0; base_rd = 0; base_d = 0;
        test_reset();
        test_single();
        test_burst();
        test_clamp_wrap();
        test_zero_len();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
